// File: rtl/reg_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// reg_xfer_ctrl
//
// Sequences register-to-register transfers over a shared 16-bit bus. The
// register set is external: this block steers its read select / output
// enable and its write select / write enable, and drives the bus itself
// only when it supplies the data (immediate load, last step of a swap).
//
// Commands:
//   00 MOV  : reg[dst] <= reg[src]          (1 execute cycle)
//   01 SWAP : exchange reg[src] and reg[dst] (3 execute cycles, optional)
//   10 LDI  : reg[dst] <= imm               (1 execute cycle)
//   11 NOP  : accepted, no bus activity
//
// Optional feature macro: REG_XFER_SWAP_EN
//   defined   -> SWAP1..SWAP3 states and the 16-bit temp register exist
//   undefined -> op 01 is accepted and treated as NOP
//
// Ports:
//   i_clk       rising-edge system clock
//   i_nReset    asynchronous active-low reset
//   i_cmdValid  command present
//   o_cmdReady  controller can accept a command (IDLE only)
//   i_cmdOp     operation code
//   i_src       source register index
//   i_dst       destination register index
//   i_imm       immediate value for LDI
//   io_bus      shared data bus (also driven by the register set)
//   o_outSel    register set read select
//   o_noe       register set output enable, active-low
//   o_writeSel  register set write select
//   o_we        register set write enable, active-high
//   o_busy      high while a command executes
// ---------------------------------------------------------------------------
module reg_xfer_ctrl (
  input  logic        i_clk,
  input  logic        i_nReset,
  input  logic        i_cmdValid,
  output logic        o_cmdReady,
  input  logic [1:0]  i_cmdOp,
  input  logic [1:0]  i_src,
  input  logic [1:0]  i_dst,
  input  logic [15:0] i_imm,
  inout  wire  [15:0] io_bus,
  output logic [1:0]  o_outSel,
  output logic        o_noe,
  output logic [1:0]  o_writeSel,
  output logic        o_we,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    MOV,
    LDI
`ifdef REG_XFER_SWAP_EN
    ,
    SWAP1,
    SWAP2,
    SWAP3
`endif
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        ready_armed;
  logic [1:0]  src_q;
  logic [1:0]  dst_q;
  logic [15:0] imm_q;
  logic        drive_en;
  logic [15:0] drive_val;
  logic        accept;
`ifdef REG_XFER_SWAP_EN
  logic [15:0] temp;
`endif

  // ready_armed stays low throughout reset and rises on the first clock edge
  // afterwards, so the controller only advertises readiness once it is
  // clocked out of reset. Busy is its complement outside reset.
  assign o_cmdReady = ready_armed && (state == IDLE);
  assign o_busy     = ready_armed && (state != IDLE);
  assign accept     = i_cmdValid && o_cmdReady;

  // The only bus drivers are LDI (immediate) and SWAP3 (temp); in every
  // other state the bus is released so the register set may drive it.
  assign io_bus = drive_en ? drive_val : 16'bz;

  // State register plus the command capture. The command fields are latched
  // at acceptance so that the execute states ignore the live inputs.
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state       <= IDLE;
      ready_armed <= 1'b0;
      src_q       <= 2'b00;
      dst_q       <= 2'b00;
      imm_q       <= 16'h0000;
`ifdef REG_XFER_SWAP_EN
      temp        <= 16'h0000;
`endif
    end else begin
      state       <= next_state;
      ready_armed <= 1'b1;
      if (accept) begin
        src_q <= i_src;
        dst_q <= i_dst;
        imm_q <= i_imm;
      end
`ifdef REG_XFER_SWAP_EN
      // The source register is on the bus during SWAP1; keep it for SWAP3.
      if (state == SWAP1) begin
        temp <= io_bus;
      end
`endif
    end
  end

  // Next-state and output decode. All outputs depend on the state register
  // and the captured command only, never directly on the command inputs.
  always_comb begin
    next_state = state;
    o_outSel   = 2'b00;
    o_noe      = 1'b1;
    o_writeSel = 2'b00;
    o_we       = 1'b0;
    drive_en   = 1'b0;
    drive_val  = 16'h0000;
    case (state)
      IDLE: begin
        if (accept) begin
          case (i_cmdOp)
            2'b00:   next_state = MOV;
            2'b10:   next_state = LDI;
`ifdef REG_XFER_SWAP_EN
            2'b01:   next_state = SWAP1;
`endif
            default: next_state = IDLE;
          endcase
        end
      end
      MOV: begin
        o_outSel   = src_q;
        o_noe      = 1'b0;
        o_writeSel = dst_q;
        o_we       = 1'b1;
        next_state = IDLE;
      end
      LDI: begin
        drive_en   = 1'b1;
        drive_val  = imm_q;
        o_writeSel = dst_q;
        o_we       = 1'b1;
        next_state = IDLE;
      end
`ifdef REG_XFER_SWAP_EN
      SWAP1: begin
        o_outSel   = src_q;
        o_noe      = 1'b0;
        next_state = SWAP2;
      end
      SWAP2: begin
        o_outSel   = dst_q;
        o_noe      = 1'b0;
        o_writeSel = src_q;
        o_we       = 1'b1;
        next_state = SWAP3;
      end
      SWAP3: begin
        drive_en   = 1'b1;
        drive_val  = temp;
        o_writeSel = dst_q;
        o_we       = 1'b1;
        next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_xfer_ctrl
//
// Bench for reg_xfer_ctrl with a behavioural four-entry register set on the
// shared bus. Expected execute-cycle outputs are queued when a command is
// issued; a monitor pops and compares one entry per busy cycle. Register
// contents, latencies and reset behaviour are checked directly.
// Builds with or without REG_XFER_SWAP_EN.
// ---------------------------------------------------------------------------
module tb_reg_xfer_ctrl;

  logic        i_clk = 1'b0;
  logic        i_nReset = 1'b1;
  logic        i_cmdValid = 1'b0;
  logic [1:0]  i_cmdOp = 2'b11;
  logic [1:0]  i_src = 2'b00;
  logic [1:0]  i_dst = 2'b00;
  logic [15:0] i_imm = 16'h0000;
  wire  [15:0] io_bus;
  logic        o_cmdReady;
  logic [1:0]  o_outSel;
  logic        o_noe;
  logic [1:0]  o_writeSel;
  logic        o_we;
  logic        o_busy;

  reg_xfer_ctrl dut (
    .i_clk      (i_clk),
    .i_nReset   (i_nReset),
    .i_cmdValid (i_cmdValid),
    .o_cmdReady (o_cmdReady),
    .i_cmdOp    (i_cmdOp),
    .i_src      (i_src),
    .i_dst      (i_dst),
    .i_imm      (i_imm),
    .io_bus     (io_bus),
    .o_outSel   (o_outSel),
    .o_noe      (o_noe),
    .o_writeSel (o_writeSel),
    .o_we       (o_we),
    .o_busy     (o_busy)
  );

  // 10-unit clock: rising edges at 5, 15, 25, ...
  always #5 i_clk = ~i_clk;

  // Behavioural register set: drives the bus when its output is enabled and
  // captures the bus on a rising edge with write enable.
  logic [15:0] regs [4];
  assign io_bus = (!o_noe) ? regs[o_outSel] : 16'bz;
  always @(posedge i_clk) begin
    if (o_we) regs[o_writeSel] <= io_bus;
  end

  typedef struct {
    logic [1:0]  out_sel;
    logic        noe;
    logic [1:0]  write_sel;
    logic        we;
    logic [15:0] bus;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  task automatic pushExp(input logic [1:0] out_sel, input logic noe,
                         input logic [1:0] write_sel, input logic we,
                         input logic [15:0] bus);
    exp_t e;
    e.out_sel   = out_sel;
    e.noe       = noe;
    e.write_sel = write_sel;
    e.we        = we;
    e.bus       = bus;
    exp_q.push_back(e);
  endtask

  // Called just after a falling edge; returns at the falling edge of the
  // first execute cycle with the command inputs withdrawn.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] src,
                               input logic [1:0] dst, input logic [15:0] imm);
    i_cmdOp    = op;
    i_src      = src;
    i_dst      = dst;
    i_imm      = imm;
    i_cmdValid = 1'b1;
    checkOutput("ready_before_accept", 32'(o_cmdReady), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_cmdValid = 1'b0;
  endtask

  // Counts busy falling edges (bounded) and checks latency and readiness.
  task automatic waitIdle(input string name, input int exp_cycles);
    int n = 0;
    while (o_busy && n < 20) begin
      n++;
      @(negedge i_clk);
    end
    checkOutput(name, 32'(n), 32'(exp_cycles));
    checkOutput("ready_when_idle", 32'(o_cmdReady), 32'd1);
  endtask

  // Monitor: one queued expectation per busy cycle.
  always @(negedge i_clk) begin
    if (i_nReset && o_busy) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_exec_cycle", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        checkOutput("exec_noe", 32'(o_noe), 32'(cur.noe));
        checkOutput("exec_we", 32'(o_we), 32'(cur.we));
        checkOutput("exec_bus", 32'(io_bus), 32'(cur.bus));
        if (!cur.noe) checkOutput("exec_outsel", 32'(o_outSel), 32'(cur.out_sel));
        if (cur.we) checkOutput("exec_writesel", 32'(o_writeSel), 32'(cur.write_sel));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 i_nReset = 1'b0;
    #2;
    checkOutput("rst_ready", 32'(o_cmdReady), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_noe", 32'(o_noe), 32'd1);
    checkOutput("rst_we", 32'(o_we), 32'd0);
    checkOutput("rst_outsel", 32'(o_outSel), 32'd0);
    checkOutput("rst_writesel", 32'(o_writeSel), 32'd0);
    @(negedge i_clk);
    i_nReset = 1'b1;
    #1 checkOutput("ready_before_first_edge", 32'(o_cmdReady), 32'd0);
    @(negedge i_clk);
    checkOutput("ready_after_release", 32'(o_cmdReady), 32'd1);

    // Preload registers through LDI: r1=1234, r3=BEEF, r0=AAAA.
    pushExp(2'd0, 1'b1, 2'd1, 1'b1, 16'h1234);
    applyStimulus(2'b10, 2'd0, 2'd1, 16'h1234);
    waitIdle("ldi_r1_cycles", 1);
    checkOutput("r1_after_ldi", 32'(regs[1]), 32'h1234);

    // MOV r1 -> r2.
    pushExp(2'd1, 1'b0, 2'd2, 1'b1, 16'h1234);
    applyStimulus(2'b00, 2'd1, 2'd2, 16'h0000);
    waitIdle("mov_cycles", 1);
    checkOutput("r2_after_mov", 32'(regs[2]), 32'h1234);

    pushExp(2'd0, 1'b1, 2'd3, 1'b1, 16'hBEEF);
    applyStimulus(2'b10, 2'd0, 2'd3, 16'hBEEF);
    waitIdle("ldi_r3_cycles", 1);
    checkOutput("r3_after_ldi", 32'(regs[3]), 32'hBEEF);

    pushExp(2'd0, 1'b1, 2'd0, 1'b1, 16'hAAAA);
    applyStimulus(2'b10, 2'd0, 2'd0, 16'hAAAA);
    waitIdle("ldi_r0_cycles", 1);

    pushExp(2'd0, 1'b1, 2'd1, 1'b1, 16'h5555);
    applyStimulus(2'b10, 2'd0, 2'd1, 16'h5555);
    waitIdle("ldi_r1b_cycles", 1);

    // Op 01 with r0=AAAA, r1=5555.
`ifdef REG_XFER_SWAP_EN
    pushExp(2'd0, 1'b0, 2'd0, 1'b0, 16'hAAAA);
    pushExp(2'd1, 1'b0, 2'd0, 1'b1, 16'h5555);
    pushExp(2'd0, 1'b1, 2'd1, 1'b1, 16'hAAAA);
    applyStimulus(2'b01, 2'd0, 2'd1, 16'h0000);
    waitIdle("swap_cycles", 3);
    checkOutput("r0_after_swap", 32'(regs[0]), 32'h5555);
    checkOutput("r1_after_swap", 32'(regs[1]), 32'hAAAA);
`else
    applyStimulus(2'b01, 2'd0, 2'd1, 16'h0000);
    checkOutput("op01_no_we", 32'(o_we), 32'd0);
    waitIdle("op01_cycles", 0);
    checkOutput("r0_after_op01", 32'(regs[0]), 32'hAAAA);
    checkOutput("r1_after_op01", 32'(regs[1]), 32'h5555);
`endif

    // NOP: accepted, never busy.
    applyStimulus(2'b11, 2'd2, 2'd3, 16'hFFFF);
    checkOutput("nop_no_we", 32'(o_we), 32'd0);
    waitIdle("nop_cycles", 0);
    checkOutput("r3_after_nop", 32'(regs[3]), 32'hBEEF);

    // src == dst MOV leaves the value unchanged.
    pushExp(2'd2, 1'b0, 2'd2, 1'b1, 16'h1234);
    applyStimulus(2'b00, 2'd2, 2'd2, 16'h0000);
    waitIdle("mov_same_cycles", 1);
    checkOutput("r2_after_mov_same", 32'(regs[2]), 32'h1234);

    // Back-to-back MOVs with valid held and dst changed mid-execution.
    pushExp(2'd3, 1'b0, 2'd0, 1'b1, 16'hBEEF);
    pushExp(2'd3, 1'b0, 2'd1, 1'b1, 16'hBEEF);
    i_cmdOp    = 2'b00;
    i_src      = 2'd3;
    i_dst      = 2'd0;
    i_cmdValid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("b2b_first_busy", 32'(o_busy), 32'd1);
    i_dst = 2'd1;
    @(negedge i_clk);
    checkOutput("b2b_idle_gap", 32'(o_cmdReady), 32'd1);
    @(negedge i_clk);
    checkOutput("b2b_second_busy", 32'(o_busy), 32'd1);
    i_dst      = 2'd2;
    i_cmdValid = 1'b0;
    @(negedge i_clk);
    checkOutput("b2b_done_ready", 32'(o_cmdReady), 32'd1);
    checkOutput("r0_after_b2b", 32'(regs[0]), 32'hBEEF);
    checkOutput("r1_after_b2b", 32'(regs[1]), 32'hBEEF);
    checkOutput("r2_after_b2b", 32'(regs[2]), 32'h1234);

    // Reset mid-command: no further write, defaults at once.
`ifdef REG_XFER_SWAP_EN
    pushExp(2'd2, 1'b0, 2'd0, 1'b0, 16'h1234);
    pushExp(2'd3, 1'b0, 2'd2, 1'b1, 16'hBEEF);
    applyStimulus(2'b01, 2'd2, 2'd3, 16'h0000);
    @(negedge i_clk);
`else
    pushExp(2'd2, 1'b0, 2'd3, 1'b1, 16'h1234);
    applyStimulus(2'b00, 2'd2, 2'd3, 16'h0000);
`endif
    #2 i_nReset = 1'b0;
    #1;
    checkOutput("abort_we", 32'(o_we), 32'd0);
    checkOutput("abort_noe", 32'(o_noe), 32'd1);
    checkOutput("abort_busy", 32'(o_busy), 32'd0);
    checkOutput("abort_ready", 32'(o_cmdReady), 32'd0);
    checkOutput("abort_outsel", 32'(o_outSel), 32'd0);
    checkOutput("abort_writesel", 32'(o_writeSel), 32'd0);
    @(negedge i_clk);
    i_nReset = 1'b1;
    #1 checkOutput("abort_ready_before_edge", 32'(o_cmdReady), 32'd0);
    @(posedge i_clk);
    #1 checkOutput("abort_ready_after_edge", 32'(o_cmdReady), 32'd1);
    checkOutput("r2_after_abort", 32'(regs[2]), 32'h1234);
    checkOutput("r3_after_abort", 32'(regs[3]), 32'hBEEF);

    @(negedge i_clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
